// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and defaults for the multicycle data-memory responder.
// The request struct is the bus bundle at the default widths.
package data_mem_ctrl_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_DEPTH       = 256;
  localparam int DEF_WAIT_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  // Width of a down-counter that must hold waits-1; never narrower than 1 bit.
  function automatic int cnt_width(input int waits);
    return (waits > 1) ? $clog2(waits) : 1;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_ram.sv
// Single-port synchronous RAM; read data is registered on enabled reads only,
// so a store leaves the last loaded word on rdata.
module data_ram #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 256,
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  en,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        rdata_q <= mem[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Multicycle load/store responder: accepts one request in IDLE, waits
// WAIT_CYCLES, does one RAM access, then pulses mem_ready for one cycle.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_err,
  output logic                  mem_busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_width(WAIT_CYCLES);
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [AW1-1:0]   DEPTH_LIM = AW1'(DEPTH);

  mem_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  zero_q, zero_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  in_range;
  logic                  ram_en;
  logic [IDX_W-1:0]      ram_idx;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Full-width compare so high address bits can never alias into the RAM.
  assign in_range = {1'b0, addr_q} < DEPTH_LIM;
  assign ram_idx  = addr_q[IDX_W-1:0];
  // Reset outranks a store whose ACCESS edge coincides with it.
  assign ram_en   = (state_q == ACCESS) && in_range && !reset;

  data_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we_q),
    .en    (ram_en),
    .idx   (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    zero_d  = zero_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          we_d    = mem_we;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        err_d   = !in_range;
        // zero_q masks the RAM read port: out-of-range forces 0, a load
        // exposes the fresh read, an in-range store keeps what was shown.
        if (!in_range) begin
          zero_d = 1'b1;
        end else if (!we_q) begin
          zero_d = 1'b0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign mem_ready = (state_q == RESP);
  assign mem_err   = mem_ready && err_q;
  assign mem_busy  = (state_q != IDLE);
  assign mem_rdata = zero_q ? '0 : ram_rdata;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Multicycle data-memory responder that services load/store requests issued by the CPU control unit during the MEM_LW / MEM_SW states.
- Accepts one request at a time over a req/ready handshake, inserts a configurable number of wait states, performs a single-cycle synchronous RAM access, then returns a one-cycle ready pulse with read data and an error flag.
- Sits between the control unit/datapath and on-chip data RAM; the control unit stalls in its MEM state until mem_ready.

Parameters:
- DATA_WIDTH, 16, word width of the RAM and the data buses
- ADDR_WIDTH, 16, width of the request address
- DEPTH, 256, number of words implemented; valid addresses are 0..DEPTH-1
- WAIT_CYCLES, 1, wait states inserted before the RAM access (0 allowed)

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-high reset
- mem_req  in  1  request strobe; sampled only in IDLE
- mem_we  in  1  1 = store, 0 = load; latched with the request
- mem_addr  in  ADDR_WIDTH  word address; latched with the request
- mem_wdata  in  DATA_WIDTH  store data; latched with the request
- mem_rdata  out  DATA_WIDTH  load data; valid while mem_ready=1, held afterwards
- mem_ready  out  1  one-cycle completion pulse
- mem_err  out  1  out-of-range flag; valid only while mem_ready=1
- mem_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset=1 at a clk edge): state=IDLE, wait counter=0, mem_ready=0, mem_err=0, mem_busy=0, mem_rdata=0. RAM contents are not cleared.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: if mem_req=1, latch we/addr/wdata. Go to WAIT (counter loaded with WAIT_CYCLES-1) when WAIT_CYCLES>0, otherwise go to ACCESS.
- WAIT: decrement the counter each cycle; go to ACCESS in the cycle the counter is 0. The state therefore lasts exactly WAIT_CYCLES cycles.
- ACCESS: exactly one cycle, with the range check latched_addr < DEPTH.
  - In range, store: RAM written at the edge ending ACCESS.
  - In range, load: RAM read synchronously; mem_rdata captured at the edge ending ACCESS.
  - Out of range: no RAM access; mem_rdata is driven 0 and mem_err is set for RESP.
  - Always go to RESP.
- RESP: mem_ready=1 for exactly one cycle, with mem_err per the range check; then go to IDLE.
  - For a store, mem_rdata keeps its previous value unless the address is out of range, in which case it is 0.
- Latency: a request sampled at edge k gives mem_ready=1 in the cycle following edge k+WAIT_CYCLES+1, i.e. WAIT_CYCLES+2 cycles after acceptance.
- Handshake rules:
  - mem_req is ignored in WAIT, ACCESS and RESP; inputs may change freely once accepted.
  - If mem_req is held high through RESP, the next request is accepted in the following IDLE cycle. There is no accept in RESP; minimum spacing is WAIT_CYCLES+3 cycles.
- Address width: addresses are compared at full ADDR_WIDTH (no truncation aliasing). The RAM index uses the low $clog2(DEPTH) bits only after the range check passes.
- Reset mid-operation: a synchronous reset in any state returns to IDLE next cycle with mem_ready=0.
  - A store not yet past the ACCESS edge is dropped.
  - A store whose ACCESS edge coincides with reset is also dropped, because reset has priority.
- Simultaneous reset and mem_req: reset wins and the request is not latched.

Decomposition:
- defs_pkg gains:
  - mem_state_t: enum IDLE, WAIT, ACCESS, RESP
  - mem_req_t: packed struct {we, addr, wdata}
  - default DEPTH and WAIT constants
- One sub-module, data_ram: single-port synchronous RAM with DATA_WIDTH and DEPTH parameters and inputs clk, we, en, idx, wdata, producing rdata registered on the enable edge. data_mem_ctrl owns the FSM, counter, latches and range check.

Test Plan:
- WAIT_CYCLES=1: store 0xBEEF to addr 0x0010, then load from 0x0010. Each mem_ready arrives 3 cycles after acceptance; the load returns mem_rdata=0xBEEF with mem_err=0; mem_busy is high for exactly 3 cycles per request.
- WAIT_CYCLES=0: load from an address pre-written with 0x1234. mem_ready follows 2 cycles after acceptance with rdata=0x1234. Also run WAIT_CYCLES=3 and check latency = 5 cycles.
- DEPTH=256: store 0xAAAA to addr 0x0100, then load 0x0100. Both responses have mem_err=1; the load returns rdata=0. A subsequent load of addr 0x0000 shows the RAM unchanged and mem_err=0.
- mem_req held high continuously with alternating addresses. Requests are accepted only in IDLE; ready pulses are spaced WAIT_CYCLES+3 cycles apart; mem_ready is never high for 2 consecutive cycles.
- Store 0x5555 to addr 0x0020, asserting reset during WAIT. No ready pulse occurs; state is IDLE next cycle; a later load of 0x0020 returns the old value, not 0x5555.
- Reset held 2 cycles at power-up with mem_req=1. All outputs are 0 and no request is latched; after release, the first request completes normally.
